onehot_seq: RTL and testbench
=============================

ONEHOT_SEQ -- requirements
Module: onehot_seq

Interface
REQ-001 SHALL have parameter W_BITS, default 3; width of select index, output width N = 2**W_BITS, legal range 1..6.
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = index 0 drives Y[N-1], 0 = index 0 drives Y[0].
REQ-003 SHALL have port Clock  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port Resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port En  input  1  global enable; gates commands and output.
REQ-006 SHALL have port Clear  input  1  return to IDLE.
REQ-007 SHALL have port Load  input  1  load index from W and go ACTIVE.
REQ-008 SHALL have port W  input  W_BITS  index to load.
REQ-009 SHALL have port Adv  input  1  advance active index by one.
REQ-010 SHALL have port Y  output  N  one-hot step vector, all-zero when idle or disabled.
REQ-011 SHALL have port Idx  output  W_BITS  current registered index.
REQ-012 SHALL have port Active  output  1  high in ACTIVE state.
REQ-013 SHALL have port Wrap  output  1  one-cycle pulse on advance from index N-1.

Function
REQ-014 SHALL hold state {IDLE, ACTIVE} plus index register idx[W_BITS-1:0] and registered Wrap flag.
REQ-015 Commands SHALL be sampled on rising Clock only while En=1; with En=0 state, idx and Wrap SHALL hold except Wrap clears to 0.
REQ-016 Priority SHALL be Clear > Load > Adv when several are high in one cycle.
REQ-017 Clear: next state IDLE, idx := 0, Wrap := 0.
REQ-018 Load (any state): next state ACTIVE, idx := W, Wrap := 0.
REQ-019 Adv in ACTIVE with idx < N-1: idx := idx+1, Wrap := 0.
REQ-020 Adv in ACTIVE with idx = N-1: idx := 0, Wrap := 1 for exactly one cycle; state per REQ-031/032.
REQ-021 Adv in IDLE SHALL be ignored (no state change, Wrap := 0).
REQ-022 No command: state and idx hold, Wrap := 0.
REQ-023 Y SHALL equal one-hot of idx (bit mapping per MSB_FIRST) when state=ACTIVE and En=1, else all-zero; Y is combinational from registers and En only.
REQ-024 Latency: command sampled at edge k SHALL be reflected on Y, Idx, Active, Wrap after edge k; no combinational path from Clear/Load/Adv/W to any output.
REQ-025 Y SHALL never have more than one bit set in any cycle.
REQ-026 Deasserting En SHALL zero Y in the same cycle; reasserting En SHALL restore Y from held state without a clock edge.

Reset
REQ-027 Resetn=0 SHALL asynchronously force state IDLE, idx=0, Wrap=0, independent of Clock.
REQ-028 During reset Y, Idx, Active, Wrap SHALL all read 0.
REQ-029 Reset asserted mid-sequence SHALL abandon the sequence; first command after release is accepted on the first rising edge with Resetn=1.
REQ-030 Reset release SHALL be synchronous-safe: no output glitch other than the reset-value hold.

Configuration
REQ-031 Macro ONEHOT_SEQ_AUTOCLR_EN defined: advance from idx=N-1 SHALL go to IDLE, idx := 0, Wrap := 1 (Y becomes all-zero).
REQ-032 Macro ONEHOT_SEQ_AUTOCLR_EN undefined: advance from idx=N-1 SHALL stay ACTIVE, idx := 0, Wrap := 1 (ring wrap, Y returns to index 0).

Verification (W_BITS=3, MSB_FIRST=1 unless stated)
REQ-033 Reset, En=1, Load W=3'b010 one cycle -> next cycle Y=8'b00100000, Idx=2, Active=1, Wrap=0.
REQ-034 Load W=6 then Adv two cycles -> Y=8'b00000001 then Wrap=1 with Y=8'b10000000 (AUTOCLR off) or Y=8'h00, Active=0 (AUTOCLR on); Wrap=0 next cycle.
REQ-035 Clear, Load W=5 and Adv all high in one cycle while ACTIVE -> Y=8'h00, Active=0, Idx=0.
REQ-036 ACTIVE at Idx=4, drop En, pulse Load W=1 and Adv -> Y=8'h00 immediately, Idx stays 4; raise En -> Y=8'b00001000 without clock.
REQ-037 Assert Resetn=0 between clock edges at Idx=7 -> Y=8'h00, Idx=0, Wrap=0 before next edge; Adv after release -> no change.
REQ-038 MSB_FIRST=0, W_BITS=2, Load W=1 -> Y=4'b0010; sweep all legal W for single-hot Y.

Source files
------------

// File: rtl/onehot_seq.sv
// One-hot step sequencer: registered index driving a gated one-hot output vector.
// Define ONEHOT_SEQ_AUTOCLR_EN to return to IDLE after wrapping past the last index.
module onehot_seq #(
    parameter int W_BITS    = 3,
    parameter int MSB_FIRST = 1
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic                     En,
    input  logic                     Clear,
    input  logic                     Load,
    input  logic [W_BITS-1:0]        W,
    input  logic                     Adv,
    output logic [(1<<W_BITS)-1:0]   Y,
    output logic [W_BITS-1:0]        Idx,
    output logic                     Active,
    output logic                     Wrap
);
    localparam int N = 1 << W_BITS;
    localparam logic [N-1:0] ONE = N'(1);
    localparam logic [N-1:0] TOP = ONE << (N - 1);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [W_BITS-1:0]   idx_q, idx_d;
    logic                wrap_q, wrap_d;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
        end
    end

    // Wrap is a pulse: any cycle that does not wrap clears it, including En=0 cycles.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        if (En) begin
            if (Clear) begin
                state_d = IDLE;
                idx_d   = '0;
            end else if (Load) begin
                state_d = ACTIVE;
                idx_d   = W;
            end else if (Adv && state_q == ACTIVE) begin
                if (&idx_q) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
`ifdef ONEHOT_SEQ_AUTOCLR_EN
                    state_d = IDLE;
`else
                    state_d = ACTIVE;
`endif
                end else begin
                    idx_d = idx_q + W_BITS'(1);
                end
            end
        end
    end

    // Output depends only on registers and En, so it can never carry more than one hot bit.
    always_comb begin
        Y = '0;
        if (En && state_q == ACTIVE) begin
            if (MSB_FIRST != 0) Y = TOP >> idx_q;
            else                Y = ONE << idx_q;
        end
    end

    assign Idx    = idx_q;
    assign Active = (state_q == ACTIVE);
    assign Wrap   = wrap_q;

endmodule

// File: tb/tb_onehot_seq.sv
// Directed self-checking bench for onehot_seq (8-bit MSB-first and 4-bit LSB-first instances).
module tb_onehot_seq;
`ifdef ONEHOT_SEQ_AUTOCLR_EN
    localparam bit AUTOCLR = 1'b1;
`else
    localparam bit AUTOCLR = 1'b0;
`endif

    logic       Clock, Resetn;
    logic       En, Clear, Load, Adv;
    logic [2:0] W;
    logic [7:0] Y;
    logic [2:0] Idx;
    logic       Active, Wrap;

    logic       b_En, b_Clear, b_Load, b_Adv;
    logic [1:0] b_W;
    logic [3:0] b_Y;
    logic [1:0] b_Idx;
    logic       b_Active, b_Wrap;

    int n_cmp = 0;
    int n_err = 0;

    onehot_seq #(.W_BITS(3), .MSB_FIRST(1)) u_dut (
        .Clock(Clock), .Resetn(Resetn), .En(En), .Clear(Clear), .Load(Load),
        .W(W), .Adv(Adv), .Y(Y), .Idx(Idx), .Active(Active), .Wrap(Wrap)
    );

    onehot_seq #(.W_BITS(2), .MSB_FIRST(0)) u_dut_lsb (
        .Clock(Clock), .Resetn(Resetn), .En(b_En), .Clear(b_Clear), .Load(b_Load),
        .W(b_W), .Adv(b_Adv), .Y(b_Y), .Idx(b_Idx), .Active(b_Active), .Wrap(b_Wrap)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Resetn = 1'b0; En = 1'b0; Clear = 1'b0; Load = 1'b0; Adv = 1'b0; W = '0;
        b_En = 1'b0; b_Clear = 1'b0; b_Load = 1'b0; b_Adv = 1'b0; b_W = '0;
        step(); step();
        chk("rst_Y", 32'(Y), 32'h0);
        chk("rst_Idx", 32'(Idx), 32'h0);
        chk("rst_Active", 32'(Active), 32'h0);
        chk("rst_Wrap", 32'(Wrap), 32'h0);
        Resetn = 1'b1; En = 1'b1;
        step();

        // Basic load
        Load = 1'b1; W = 3'd2;
        step();
        Load = 1'b0;
        chk("load2_Y", 32'(Y), 32'h20);
        chk("load2_Idx", 32'(Idx), 32'd2);
        chk("load2_Active", 32'(Active), 32'h1);
        chk("load2_Wrap", 32'(Wrap), 32'h0);

        // Load 6, advance through the top index
        Load = 1'b1; W = 3'd6;
        step();
        Load = 1'b0;
        chk("load6_Y", 32'(Y), 32'h02);
        Adv = 1'b1;
        step();
        chk("adv7_Y", 32'(Y), 32'h01);
        chk("adv7_Wrap", 32'(Wrap), 32'h0);
        step();
        Adv = 1'b0;
        chk("wrap_Wrap", 32'(Wrap), 32'h1);
        chk("wrap_Idx", 32'(Idx), 32'h0);
        chk("wrap_Y", 32'(Y), AUTOCLR ? 32'h00 : 32'h80);
        chk("wrap_Active", 32'(Active), AUTOCLR ? 32'h0 : 32'h1);
        step();
        chk("postwrap_Wrap", 32'(Wrap), 32'h0);

        // Clear beats Load and Adv
        Load = 1'b1; W = 3'd3;
        step();
        Clear = 1'b1; Load = 1'b1; W = 3'd5; Adv = 1'b1;
        step();
        Clear = 1'b0; Load = 1'b0; Adv = 1'b0;
        chk("prio_Y", 32'(Y), 32'h0);
        chk("prio_Active", 32'(Active), 32'h0);
        chk("prio_Idx", 32'(Idx), 32'h0);

        // Adv in IDLE is ignored
        Adv = 1'b1;
        step();
        Adv = 1'b0;
        chk("idle_adv_Idx", 32'(Idx), 32'h0);
        chk("idle_adv_Active", 32'(Active), 32'h0);

        // Enable gating: commands ignored, Y zeroed and restored without a clock
        Load = 1'b1; W = 3'd4;
        step();
        Load = 1'b0;
        chk("load4_Idx", 32'(Idx), 32'd4);
        En = 1'b0; Load = 1'b1; W = 3'd1; Adv = 1'b1;
        #1;
        chk("dis_Y_now", 32'(Y), 32'h0);
        step();
        chk("dis_Idx", 32'(Idx), 32'd4);
        chk("dis_Active", 32'(Active), 32'h1);
        chk("dis_Y", 32'(Y), 32'h0);
        Load = 1'b0; Adv = 1'b0;
        En = 1'b1;
        #1;
        chk("reen_Y", 32'(Y), 32'h08);

        // Wrap clears on a disabled cycle
        Load = 1'b1; W = 3'd7;
        step();
        Load = 1'b0; Adv = 1'b1;
        step();
        Adv = 1'b0;
        chk("wrap2_Wrap", 32'(Wrap), 32'h1);
        En = 1'b0;
        step();
        chk("dis_wrap_clr", 32'(Wrap), 32'h0);
        chk("dis_wrap_Active", 32'(Active), AUTOCLR ? 32'h0 : 32'h1);
        En = 1'b1;

        // Asynchronous reset mid-sequence
        Load = 1'b1; W = 3'd7;
        step();
        Load = 1'b0;
        chk("pre_rst_Idx", 32'(Idx), 32'd7);
        #2 Resetn = 1'b0;
        #1;
        chk("arst_Y", 32'(Y), 32'h0);
        chk("arst_Idx", 32'(Idx), 32'h0);
        chk("arst_Wrap", 32'(Wrap), 32'h0);
        chk("arst_Active", 32'(Active), 32'h0);
        #1 Resetn = 1'b1;
        Adv = 1'b1;
        step();
        Adv = 1'b0;
        chk("post_rst_adv_Idx", 32'(Idx), 32'h0);
        chk("post_rst_adv_Active", 32'(Active), 32'h0);

        // Sweep every index on the MSB-first instance
        for (int w = 0; w < 8; w++) begin
            Load = 1'b1; W = 3'(w);
            step();
            chk($sformatf("sweep8_Y_%0d", w), 32'(Y), 32'h80 >> w);
            chk($sformatf("sweep8_hot_%0d", w), 32'($countones(Y)), 32'd1);
        end
        Load = 1'b0;

        // LSB-first 4-bit instance
        b_En = 1'b1; b_Load = 1'b1; b_W = 2'd1;
        step();
        chk("lsb_load1_Y", 32'(b_Y), 32'h2);
        for (int w = 0; w < 4; w++) begin
            b_W = 2'(w);
            step();
            chk($sformatf("sweep4_Y_%0d", w), 32'(b_Y), 32'h1 << w);
            chk($sformatf("sweep4_hot_%0d", w), 32'($countones(b_Y)), 32'd1);
        end
        b_Load = 1'b0; b_Adv = 1'b1;
        step();
        b_Adv = 1'b0;
        chk("lsb_wrap", 32'(b_Wrap), 32'h1);
        chk("lsb_wrap_Y", 32'(b_Y), AUTOCLR ? 32'h0 : 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
